obstacle_scroller: RTL and testbench
====================================

# obstacle_scroller

Parametrised board engine for the dodge game. It scrolls a WIDTH×HEIGHT obstacle board down one row every `period` clock cycles, and takes new top rows from the row generator through a valid/ready handshake. It also checks the bottom row against the player mask, latches game-over, and counts survived rows. It sits between the row generator and the display/score logic, and adds a start/pause/over control FSM and a programmable scroll rate.

## Interface
- `WIDTH`, 9, columns per row
- `HEIGHT`, 16, rows on the board; must be ≥ 2
- `PERIOD_W`, 8, width of the scroll-period input and tick counter
- `SCORE_W`, 10, width of the score counter
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  level; begins a game from IDLE or OVER
- `pause`  in  1  level; freezes play while high
- `period`  in  PERIOD_W  cycles between shifts; 0 is treated as 1
- `row_valid`  in  1  generator offers `row_data`
- `row_data`  in  WIDTH  candidate top row; bit set = obstacle
- `row_ready`  out  1  row consumed this cycle (transfer = `row_valid` && `row_ready`)
- `player_mask`  in  WIDTH  player occupancy in the bottom row
- `obstacle_data`  out  WIDTH × [0:HEIGHT-1]  registered board; index 0 = top
- `shift_pulse`  out  1  one-cycle strobe, high in the cycle the new board is first visible
- `score`  out  SCORE_W  rows survived, saturating
- `game_over`  out  1  high while in OVER
- `state`  out  2  current FSM state (`state_t`)

## Operation
- States:
  - IDLE: board cleared, waiting for a game.
  - RUN: board scrolls and collisions are checked.
  - PAUSED: board and tick counter hold.
  - OVER: board, score and counter hold.
- Transitions:
  - IDLE → RUN on `start`.
  - RUN → OVER on collision (priority 1).
  - RUN → PAUSED on `pause` (priority 2).
  - PAUSED → RUN when `pause` = 0.
  - OVER → RUN on `start`.
- Entering RUN from IDLE or OVER clears the board, `score` and `tick` to 0.
- `start` is ignored in RUN and PAUSED. `pause` is ignored outside RUN and PAUSED.
- Collision is `|(obstacle_data[HEIGHT-1] & player_mask)`. It is evaluated only in RUN, every cycle, on the registered board.
- `eff_period` = max(`period`, 1).
- Tick counter runs in RUN only. `shift_en` = RUN && !collision && !`pause` && (`tick` ≥ `eff_period`−1).
  - On `shift_en`, `tick` goes to 0; otherwise `tick` increments.
  - Using ≥ means that lowering `period` mid-count forces an immediate shift.
- On `shift_en`:
  - `obstacle_data[j]` ← `obstacle_data[j-1]` for j = HEIGHT−1..1.
  - `obstacle_data[0]` ← `row_valid` ? `row_data` : 0. An empty row is inserted when the generator is not ready; no stall.
- `row_ready` = `shift_en`, combinational. It never asserts outside RUN.
- Score: on `shift_en` with `obstacle_data[HEIGHT-1]` ≠ 0, `score` += 1, saturating at all-ones.
- Collision has priority over shift in the same cycle: no shift, no score, `row_ready` = 0.
- Reset values:
  - `state` = IDLE
  - board all 0
  - `score` = 0
  - `tick` = 0
  - `shift_pulse` = 0
  - `game_over` = 0
- Reset overrides everything, including mid-game.

## Timing
- Board, `score`, `state`, `shift_pulse` and `game_over` are all registered.
- A shift at edge N makes the new board visible in cycle N+1, with `shift_pulse` high for exactly that cycle.
- With constant `period` = P and no pause, the first shift occurs P cycles after entering RUN. Shifts then repeat every P cycles.
- Collision seen in cycle N puts `game_over` = 1 from cycle N+1.
- A pause lasting K cycles delays the next shift by exactly K cycles, because `tick` is held.
- `row_ready` and `shift_en` depend combinationally on `player_mask` and `pause`. The generator must not make `row_valid` depend on `row_ready`.

## Structure
- Package `obstacle_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSED, OVER}, 2-bit.
  - Default parameter constants.
- Sub-module `scroll_timer`:
  - Parameter `PERIOD_W`.
  - Inputs: `clk`, `reset`, `clear`, `enable`, `period`.
  - Output: `expire`.
  - Implements `eff_period`, the ≥ compare and the hold behaviour.
  - The top module gates `expire` with collision and `pause` to form `shift_en`.
- Remaining logic is the FSM, board shift register, score counter and collision reduction.

## Test plan
- Reset, then `start` with `period` = 3, `row_valid` = 1, `row_data` = 9'h02A, `player_mask` = 0 → first `shift_pulse` 3 cycles after RUN; `obstacle_data[0]` = 9'h02A; `row_ready` high one cycle per shift.
- `row_valid` = 0 at a shift → `obstacle_data[0]` = 0; no stall; subsequent shifts remain every 3 cycles.
- Fill the board with 9'h001 rows, `player_mask` = 9'h100, run 20 shifts → `score` increments by 1 per nonzero bottom row; `score` = 5 after the fifth nonzero row leaves.
- Bottom row 9'h010 with `player_mask` = 9'h010 on a shift cycle → no shift, `row_ready` = 0, `game_over` = 1 next cycle; board frozen; `start` clears the board and `score` to 0 and returns to RUN.
- `pause` for 5 cycles mid-count at `tick` = 1 (`period` = 4) → board and `tick` hold; next shift 7 cycles after the pause began; collision mask ignored while PAUSED.
- `period` = 0 → shift every cycle. `period` dropped from 10 to 2 at `tick` = 6 → shift on the next edge. `reset` asserted mid-game → IDLE, board and `score` zero, `game_over` = 0.

Source files
------------

// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared state encoding and default sizes for the obstacle scroller
package obstacle_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;
  localparam int WIDTH_DEF = 9;
  localparam int HEIGHT_DEF = 16;
  localparam int PERIOD_W_DEF = 8;
  localparam int SCORE_W_DEF = 10;
endpackage

// File: rtl/obstacle_scroller_timer.sv
// scroll_timer: programmable tick counter that flags when a scroll is due
module scroll_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);
  logic [PERIOD_W-1:0] tick_q, tick_d, eff_period;
  always_comb begin
    eff_period = (period == '0) ? PERIOD_W'(1) : period;
    expire = enable && (tick_q >= eff_period - PERIOD_W'(1));
    tick_d = clear ? '0 : enable ? tick_q + PERIOD_W'(1) : tick_q;
  end
  always_ff @(posedge clk) begin
    if (reset) tick_q <= '0;
    else tick_q <= tick_d;
  end
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: scrolling obstacle board with collision, score and game-state control
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic [PERIOD_W-1:0] period,
  input  logic                row_valid,
  input  logic [WIDTH-1:0]    row_data,
  output logic                row_ready,
  input  logic [WIDTH-1:0]    player_mask,
  output logic [WIDTH-1:0]    obstacle_data [0:HEIGHT-1],
  output logic                shift_pulse,
  output logic [SCORE_W-1:0]  score,
  output logic                game_over,
  output logic [1:0]          state
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] board_q [0:HEIGHT-1];
  logic [WIDTH-1:0] board_d [0:HEIGHT-1];
  logic [SCORE_W-1:0] score_q, score_d;
  logic shift_pulse_q, shift_pulse_d, game_over_q, game_over_d;
  logic run, expire, collision, start_game, shift_en;
  assign run = (state_q == RUN);
  assign collision = run && |(board_q[HEIGHT-1] & player_mask);
  assign start_game = (state_q == IDLE || state_q == OVER) && start;
  assign shift_en = expire && !collision && !pause;
  scroll_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(start_game || shift_en),
    .enable(run),
    .period(period),
    .expire(expire)
  );
  always_comb begin
    state_d = start_game ? RUN
            : collision ? OVER
            : (run && pause) ? PAUSED
            : (state_q == PAUSED && !pause) ? RUN
            : state_q;
    board_d[0] = start_game ? '0 : shift_en ? (row_valid ? row_data : '0) : board_q[0];
    for (int j = 1; j < HEIGHT; j++)
      board_d[j] = start_game ? '0 : shift_en ? board_q[j-1] : board_q[j];
    score_d = start_game ? '0
            : (shift_en && |board_q[HEIGHT-1] && !(&score_q)) ? score_q + SCORE_W'(1)
            : score_q;
    shift_pulse_d = shift_en;
    game_over_d = (state_d == OVER);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '{default: '0};
      score_q <= '0;
      shift_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      shift_pulse_q <= shift_pulse_d;
      game_over_q <= game_over_d;
    end
  end
  assign row_ready = shift_en;
  assign obstacle_data = board_q;
  assign shift_pulse = shift_pulse_q;
  assign score = score_q;
  assign game_over = game_over_q;
  assign state = state_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: directed table and sequence checks for obstacle_scroller
module tb_obstacle_scroller;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, row_valid = 1'b0;
  logic row_ready, shift_pulse, game_over;
  logic [7:0] period = 8'd0;
  logic [8:0] row_data = 9'h0, player_mask = 9'h0;
  logic [8:0] obstacle_data [0:3];
  logic [2:0] score;
  logic [1:0] state;
  int tests = 0, fails = 0;
  typedef struct {
    logic st_in; logic pa; logic [7:0] per; logic rv; logic [8:0] rd; logic [8:0] pm;
    logic [1:0] st; logic sp; logic rr; logic [8:0] top; logic [8:0] bot; logic [2:0] sc; logic go;
  } vec_t;
  vec_t tab [17];
  always #5 clk = ~clk;
  obstacle_scroller #(.WIDTH(9), .HEIGHT(4), .PERIOD_W(8), .SCORE_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .period(period),
    .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
    .player_mask(player_mask), .obstacle_data(obstacle_data), .shift_pulse(shift_pulse),
    .score(score), .game_over(game_over), .state(state)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; player_mask = 9'h0;
    next(); next();
    reset = 1'b0;
  endtask
  initial begin
    tab[0]  = '{1'b1, 1'b1, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd0, 1'b0, 1'b0, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[3]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b1, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[4]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b1, 1'b0, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[5]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 8'd3, 1'b0, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b1, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[7]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b1, 1'b0, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[8]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[9]  = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b1, 9'h000, 9'h000, 3'd0, 1'b0};
    tab[10] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b1, 1'b0, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[11] = '{1'b1, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[12] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b1, 9'h02A, 9'h000, 3'd0, 1'b0};
    tab[13] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b1, 1'b0, 9'h02A, 9'h02A, 3'd0, 1'b0};
    tab[14] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b0, 9'h02A, 9'h02A, 3'd0, 1'b0};
    tab[15] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b0, 1'b1, 9'h02A, 9'h02A, 3'd0, 1'b0};
    tab[16] = '{1'b0, 1'b0, 8'd3, 1'b1, 9'h02A, 9'h0, 2'd1, 1'b1, 1'b0, 9'h02A, 9'h000, 3'd1, 1'b0};
    do_reset();
    chk("reset state", state, 2'd0);
    chk("reset score", score, 3'd0);
    chk("reset game_over", game_over, 1'b0);
    chk("reset shift_pulse", shift_pulse, 1'b0);
    for (int i = 0; i < 17; i++) begin
      start = tab[i].st_in; pause = tab[i].pa; period = tab[i].per;
      row_valid = tab[i].rv; row_data = tab[i].rd; player_mask = tab[i].pm;
      @(negedge clk);
      chk($sformatf("A%0d state", i), state, tab[i].st);
      chk($sformatf("A%0d shift_pulse", i), shift_pulse, tab[i].sp);
      chk($sformatf("A%0d row_ready", i), row_ready, tab[i].rr);
      chk($sformatf("A%0d top", i), obstacle_data[0], tab[i].top);
      chk($sformatf("A%0d bottom", i), obstacle_data[3], tab[i].bot);
      chk($sformatf("A%0d score", i), score, tab[i].sc);
      chk($sformatf("A%0d game_over", i), game_over, tab[i].go);
      next();
    end
    do_reset();
    period = 8'd0; row_valid = 1'b1; row_data = 9'h001; player_mask = 9'h100; start = 1'b1;
    next();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("B%0d score", n), score, n < 6 ? 0 : (n - 5 > 7 ? 7 : n - 5));
      chk($sformatf("B%0d shift_pulse", n), shift_pulse, n >= 2);
      chk($sformatf("B%0d row_ready", n), row_ready, 1'b1);
      if (n == 4) chk("B4 bottom", obstacle_data[3], 9'h000);
      if (n == 5) chk("B5 bottom", obstacle_data[3], 9'h001);
      next();
    end
    player_mask = 9'h011;
    @(negedge clk);
    chk("C collide row_ready", row_ready, 1'b0);
    chk("C collide state", state, 2'd1);
    next();
    for (int k = 0; k < 3; k++) begin
      pause = (k > 0);
      @(negedge clk);
      chk($sformatf("C%0d over state", k), state, 2'd3);
      chk($sformatf("C%0d game_over", k), game_over, 1'b1);
      chk($sformatf("C%0d shift_pulse", k), shift_pulse, 1'b0);
      chk($sformatf("C%0d bottom frozen", k), obstacle_data[3], 9'h001);
      chk($sformatf("C%0d score held", k), score, 3'd7);
      chk($sformatf("C%0d row_ready", k), row_ready, 1'b0);
      next();
    end
    pause = 1'b0; player_mask = 9'h0; start = 1'b1;
    next();
    start = 1'b0;
    @(negedge clk);
    chk("C restart state", state, 2'd1);
    chk("C restart score", score, 3'd0);
    chk("C restart top", obstacle_data[0], 9'h000);
    chk("C restart bottom", obstacle_data[3], 9'h000);
    chk("C restart game_over", game_over, 1'b0);
    next();
    do_reset();
    period = 8'd4; row_valid = 1'b1; row_data = 9'h1FF; start = 1'b1;
    next();
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      pause = (c >= 18 && c <= 22);
      player_mask = (c >= 19 && c <= 22) ? 9'h1FF : 9'h000;
      @(negedge clk);
      chk($sformatf("D%0d shift_pulse", c), shift_pulse, c == 5 || c == 9 || c == 13 || c == 17 || c == 26);
      chk($sformatf("D%0d game_over", c), game_over, 1'b0);
      chk($sformatf("D%0d score", c), score, c == 26);
      if (c >= 19 && c <= 23) chk($sformatf("D%0d paused", c), state, 2'd2);
      if (c >= 17) chk($sformatf("D%0d bottom", c), obstacle_data[3], 9'h1FF);
      next();
    end
    reset = 1'b1;
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("F state", state, 2'd0);
    chk("F top", obstacle_data[0], 9'h000);
    chk("F bottom", obstacle_data[3], 9'h000);
    chk("F score", score, 3'd0);
    chk("F game_over", game_over, 1'b0);
    chk("F row_ready", row_ready, 1'b0);
    next();
    period = 8'd10; row_valid = 1'b1; row_data = 9'h0AA; start = 1'b1;
    next();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 7) period = 8'd2;
      @(negedge clk);
      chk($sformatf("E%0d row_ready", c), row_ready, c == 7);
      chk($sformatf("E%0d shift_pulse", c), shift_pulse, c == 8);
      if (c == 8) chk("E8 top", obstacle_data[0], 9'h0AA);
      next();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
